// File: rtl/y_calculator.sv
// y_calculator: CORDIC Y-update stage, y_out <= y +/- x_shift in binary32, one-cycle latency
module y_calculator (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] y,
   input  logic [31:0] angle,
   input  logic [31:0] x_shift,
   output logic [31:0] y_out
);
   logic        w_sa, w_sb, w_s1, w_s2, w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_swap, w_eff_sub, w_up;
   logic [7:0]  w_ea, w_eb, w_e1, w_e2, w_d;
   logic [22:0] w_fa, w_fb, w_f1, w_f2;
   logic [23:0] w_sig1, w_sig2;
   logic [26:0] w_al, w_norm;
   logic [53:0] w_full;
   logic [27:0] w_sum, w_sh;
   logic [4:0]  w_lz;
   logic [24:0] w_rnd;
   logic [9:0]  w_e;
   logic [31:0] w_res;
   logic [31:0] r_y;

   // unpack, align, add, normalise and round; specials override the arithmetic result
   always_comb begin
      w_sa    = y[31];
      w_sb    = x_shift[31] ^ angle[31];
      w_ea    = y[30:23];
      w_eb    = x_shift[30:23];
      w_nan_a = (&w_ea) && (|y[22:0]);
      w_nan_b = (&w_eb) && (|x_shift[22:0]);
      w_inf_a = (&w_ea) && !(|y[22:0]);
      w_inf_b = (&w_eb) && !(|x_shift[22:0]);
      w_fa    = (w_ea == 8'd0) ? 23'd0 : y[22:0];
      w_fb    = (w_eb == 8'd0) ? 23'd0 : x_shift[22:0];
      w_swap  = {w_eb, w_fb} > {w_ea, w_fa};
      w_s1    = w_swap ? w_sb : w_sa;
      w_e1    = w_swap ? w_eb : w_ea;
      w_f1    = w_swap ? w_fb : w_fa;
      w_s2    = w_swap ? w_sa : w_sb;
      w_e2    = w_swap ? w_ea : w_eb;
      w_f2    = w_swap ? w_fa : w_fb;
      w_sig1  = {|w_e1, w_f1};
      w_sig2  = {|w_e2, w_f2};
      w_d     = w_e1 - w_e2;
      w_full  = {w_sig2, 3'b000, 27'd0} >> w_d;
      w_al    = (w_d >= 8'd27) ? {26'd0, |w_sig2} : {w_full[53:28], w_full[27] | (|w_full[26:0])};
      w_eff_sub = w_s1 ^ w_s2;
      w_sum   = w_eff_sub ? {1'b0, w_sig1, 3'b000} - {1'b0, w_al} : {1'b0, w_sig1, 3'b000} + {1'b0, w_al};
      w_lz    = 5'd28;
      for (int i = 0; i < 28; i++)
         if (w_sum[i]) w_lz = 5'(27 - i);
      w_sh    = w_sum << w_lz;
      w_norm  = {w_sh[27:2], w_sh[1] | w_sh[0]};
      w_up    = w_norm[2] && (w_norm[1] || w_norm[0] || w_norm[3]);
      w_rnd   = {1'b0, w_norm[26:3]} + {24'd0, w_up};
      w_e     = {2'b00, w_e1} + 10'd1 - {5'd0, w_lz} + {9'd0, w_rnd[24]};
      w_res   = (w_nan_a || w_nan_b) ? 32'h7FC00000 :
                (w_inf_a && w_inf_b && (w_sa != w_sb)) ? 32'h7FC00000 :
                w_inf_a ? {w_sa, 8'hFF, 23'd0} :
                w_inf_b ? {w_sb, 8'hFF, 23'd0} :
                (w_sum == 28'd0) ? {w_s1 && !w_eff_sub, 31'd0} :
                (w_e[9] || w_e == 10'd0) ? 32'h00000000 :
                (w_e >= 10'd255) ? {w_s1, 8'hFF, 23'd0} :
                {w_s1, w_e[7:0], w_rnd[22:0]};
   end

   // output register; reset wins over the data update
   always_ff @(posedge clock) begin
      if (reset) r_y <= 32'h00000000;
      else       r_y <= w_res;
   end

   assign y_out = r_y;
endmodule

// File: tb/tb_y_calculator.sv
// tb_y_calculator: directed vectors with hand-computed binary32 results for y_calculator
module tb_y_calculator;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] y = 32'd0, angle = 32'd0, x_shift = 32'd0;
   logic [31:0] y_out;
   int          passed = 0, total = 0;

   y_calculator dut (
      .clock(clock), .reset(reset), .y(y), .angle(angle), .x_shift(x_shift), .y_out(y_out)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] exp);
      total++;
      assert (y_out === exp) passed++;
      else $error("FAIL %s: y_out=%h expected=%h", tag, y_out, exp);
   endtask

   task automatic step(input logic [31:0] yy, input logic [31:0] aa, input logic [31:0] xx,
                       input string tag, input logic [31:0] exp);
      y = yy; angle = aa; x_shift = xx;
      @(posedge clock); #1;
      check(tag, exp);
   endtask

   initial begin
      y = 32'h3F800000; x_shift = 32'h3F800000; reset = 1'b1;
      @(posedge clock); @(posedge clock); #1;
      check("reset", 32'h00000000);
      reset = 1'b0;
      step(32'h3F800000, 32'h00000000, 32'h3F800000, "1+1",          32'h40000000);
      step(32'h30000000, 32'h80000000, 32'h0A000000, "tiny_sub",     32'h30000000);
      step(32'hA1000000, 32'h00000001, 32'h4A000005, "tiny_add",     32'h4A000005);
      step(32'h026E8B75, 32'h80000000, 32'h00000003, "sub_flush",    32'h026E8B75);
      step(32'h3FC00000, 32'hBF000000, 32'h3F800000, "1.5-1",        32'h3F000000);
      step(32'h3F800000, 32'h80000000, 32'h3F800000, "cancel",       32'h00000000);
      step(32'h7F7FFFFF, 32'h00000000, 32'h7F7FFFFF, "overflow",     32'h7F800000);
      step(32'h7FC00001, 32'h00000000, 32'h3F800000, "nan_in",       32'h7FC00000);
      step(32'h3F800000, 32'h00000000, 32'hFF800001, "nan_x",        32'h7FC00000);
      step(32'h80000000, 32'h80000000, 32'h00000000, "neg0+neg0",    32'h80000000);
      step(32'h7F800000, 32'h80000000, 32'h7F800000, "inf-inf",      32'h7FC00000);
      step(32'h7F800000, 32'h00000000, 32'hFF800000, "inf+-inf",     32'h7FC00000);
      step(32'hFF800000, 32'h00000000, 32'h3F800000, "-inf+1",       32'hFF800000);
      step(32'h3F800000, 32'h80000000, 32'h7F800000, "1-inf",        32'hFF800000);
      step(32'h3F800000, 32'h00000000, 32'h33800000, "tie_even",     32'h3F800000);
      step(32'h3F800001, 32'h00000000, 32'h33800000, "tie_odd",      32'h3F800002);
      step(32'h00800001, 32'h80000000, 32'h00800000, "uflow",        32'h00000000);
      step(32'hC0000000, 32'h00000000, 32'h3F800000, "-2+1",         32'hBF800000);
      step(32'h40400000, 32'h00000000, 32'h40A00000, "3+5",          32'h41000000);
      y = 32'h40400000; angle = 32'h00000000; x_shift = 32'h40A00000; reset = 1'b1;
      @(posedge clock); #1;
      check("mid_reset", 32'h00000000);
      reset = 1'b0;
      step(32'h40400000, 32'h80000000, 32'h40A00000, "3-5",          32'hC0000000);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/y_calculator.md
Name: y_calculator

Overview:
- Single CORDIC rotation-mode Y-update stage for IEEE-754 single-precision values.
- Computes y_next = y + d·x_shift, where d = +1 if the residual angle is non-negative and d = −1 if it is negative.
- x_shift is the already-scaled x term (x·2^-i), supplied by the neighbouring shift stage.
- Result is registered; one instance per CORDIC iteration, alongside the X and angle calculators.

Parameters:
- None. Data width is fixed at 32 bits (IEEE-754 binary32).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- y  input  32  current Y coordinate, binary32.
- angle  input  32  current residual angle; only bit 31 (the sign) is used.
- x_shift  input  32  shifted X term, binary32.
- y_out  output  32  registered result, binary32.

Interface: one clock (clock); reset is synchronous and active-high (reset).

Behaviour:
- Reset: on a rising edge with reset=1, y_out <= 32'h00000000. Reset has priority over the data update.
- Latency: 1 cycle. Inputs sampled at edge N appear on y_out after edge N; new inputs are accepted every cycle.
- There is no handshake and no valid signal.
- Direction select:
  - angle[31]=0 → y_out = y + x_shift.
  - angle[31]=1 → y_out = y − x_shift.
  - angle 32'h80000000 (−0.0) counts as negative.
- Subtraction is implemented as addition with x_shift's sign flipped.
- Float add datapath:
  - Unpack sign, 8-bit exponent, 24-bit significand (hidden 1).
  - Swap operands so that the larger magnitude comes first.
  - Align the smaller operand by the exponent difference, keeping guard, round and sticky bits.
  - If the shift is ≥ 27, the smaller operand contributes only to sticky.
  - Add or subtract the significands; normalise with a leading-zero count.
  - Round to nearest, ties to even.
  - Renormalise if rounding carries out.
- Special cases:
  - Subnormal inputs (exp=0, mantissa≠0) are flushed to zero of the same sign before the operation.
  - Subnormal results are flushed to +0.
  - Exact cancellation gives +0. (−0) + (−0) gives −0.
  - Either operand NaN → 32'h7FC00000.
  - Inf − Inf of equal sign under subtraction (or opposite-sign add) → 32'h7FC00000.
  - Inf with a finite operand → that Inf.
  - Exponent overflow after rounding → ±Inf (exp=8'hFF, mantissa 0).
- Purely combinational arithmetic feeding one 32-bit output register. No other state.

Test Plan:
- Reset asserted for 2 cycles → y_out=32'h00000000. Then deassert, apply y=32'h3F800000, x_shift=32'h3F800000, angle=32'h00000000 → y_out=32'h40000000 (1+1=2) one edge later.
- y=32'h30000000, angle=32'h80000000, x_shift=32'h0A000000 → y_out=32'h30000000 (negligible subtrahend; exponent gap > 27).
- y=32'hA1000000, angle=32'h00000001, x_shift=32'h4A000005 → y_out=32'h4A000005 (negligible addend).
- y=32'h026E8B75, angle=32'h80000000, x_shift=32'h00000003 → y_out=32'h026E8B75 (subnormal x_shift flushed to zero).
- Subtraction and cancellation:
  - y=32'h3FC00000, x_shift=32'h3F800000, angle=32'hBF000000 → y_out=32'h3F000000 (1.5−1.0).
  - y=x_shift=32'h3F800000 with angle negative → y_out=32'h00000000.
- Specials:
  - y=32'h7F7FFFFF, x_shift=32'h7F7FFFFF, angle positive → y_out=32'h7F800000 (overflow to +Inf).
  - y=32'h7FC00001, any x_shift → y_out=32'h7FC00000.
  - Reset asserted mid-stream → y_out=0 on that edge regardless of inputs.
